// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared definitions for the serial adder sequencer and its helpers.
//   - state_e : FSM state encoding (IDLE / SHIFT / DONE, 2 bits)
//   - clog2   : ceiling log2, used to size counters and the bit index
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Number of bits needed to hold values 0..v-1 (returns 0 for v <= 1).
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_adder_step_tick_gen.sv
// step_tick_gen
//   Clock-enable divider: produces a one-cycle TICK every DIV cycles of
//   CLK_IN while EN is high, so slow logic stays in the CLK_IN domain
//   instead of running on a derived clock.
// Ports:
//   CLK_IN : system clock, rising edge
//   RST_N  : asynchronous active-low reset
//   EN     : count while high; the counter holds and TICK stays low otherwise
//   CLR    : synchronous clear of counter and TICK (wins over EN)
//   TICK   : registered enable pulse, high for one cycle per DIV enabled cycles
module step_tick_gen
  import serial_adder_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CNT_W = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count_q;
  logic             tick_q;

  // Counter runs 0..DIV-1 while enabled and wraps on its last value. The
  // pulse is registered, so it appears in the cycle after the counter sat
  // on DIV-1; this keeps TICK glitch-free for whatever consumes it.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (CLR) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else if (EN) begin
      tick_q  <= (count_q == CNT_LAST);
      count_q <= (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
    end else begin
      tick_q  <= 1'b0;
    end
  end

  assign TICK = tick_q;

endmodule

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
//   Sequencer for a bit-serial adder. On an accepted START the operands and
//   carry-in are captured, then one bit per step tick is added LSB first
//   through a carry flip-flop. The parallel sum and carry-out are published
//   together with a one-cycle DONE pulse.
// Ports:
//   CLK_IN  : system clock, rising edge
//   RST_N   : asynchronous active-low reset
//   START   : operation request, only looked at in IDLE
//   ABORT   : synchronous cancel, only honoured in SHIFT
//   A_IN    : operand A, captured on START acceptance
//   B_IN    : operand B, captured on START acceptance
//   CIN     : carry-in, captured on START acceptance
//   BUSY    : high in SHIFT and DONE
//   DONE    : one-cycle result-valid pulse
//   SUM_OUT : registered sum (mod 2^WIDTH), held until the next completion
//   COUT    : registered carry-out, held with SUM_OUT
//   SUM_BIT : sum bit produced by the most recent step
//   BIT_IDX : index of the bit being added
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic                      CLK_IN,
  input  logic                      RST_N,
  input  logic                      START,
  input  logic                      ABORT,
  input  logic [WIDTH-1:0]          A_IN,
  input  logic [WIDTH-1:0]          B_IN,
  input  logic                      CIN,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [WIDTH-1:0]          SUM_OUT,
  output logic                      COUT,
  output logic                      SUM_BIT,
  output logic [clog2(WIDTH)-1:0]   BIT_IDX
);

  localparam int IDX_W = clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sumOut_q;
  logic             cout_q;
  logic             sumBit_q;

  logic             tick;
  logic             tickEn;
  logic             tickClr;
  logic             sumBit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_d;

  // The divider only runs during SHIFT and restarts from zero on every
  // accepted START and on ABORT, so each operation sees identical step timing.
  assign tickEn  = (state_q == ST_SHIFT);
  assign tickClr = ((state_q == ST_IDLE) && START) ||
                   ((state_q == ST_SHIFT) && ABORT);

  step_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .EN     (tickEn),
    .CLR    (tickClr),
    .TICK   (tick)
  );

  // Full-adder bit on the current LSBs; the new sum bit enters the sum
  // register at the MSB so after WIDTH steps bit 0 lands at the LSB.
  always_comb begin
    sumBit_d = a_q[0] ^ b_q[0] ^ carry_q;
    carry_d  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    sum_d    = {sumBit_d, sum_q[WIDTH-1:1]};
  end

  // FSM with all outputs registered. DONE is a single-cycle state; ABORT
  // drops straight back to IDLE leaving the previous result untouched.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sumOut_q <= '0;
      cout_q   <= 1'b0;
      sumBit_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (START) begin
            a_q     <= A_IN;
            b_q     <= B_IN;
            carry_q <= CIN;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (ABORT) begin
            idx_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (tick) begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            sumBit_q <= sumBit_d;
            if (idx_q == IDX_LAST) begin
              idx_q    <= '0;
              sumOut_q <= sum_d;
              cout_q   <= carry_d;
              done_q   <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign SUM_OUT = sumOut_q;
  assign COUT    = cout_q;
  assign SUM_BIT = sumBit_q;
  assign BIT_IDX = idx_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
//   Two instances: an 8-bit adder stepping every 4 cycles and a 4-bit adder
//   stepping every cycle. Expected results come from an arithmetic model and
//   are queued when an operation is started, then popped on DONE.
module tb_serial_adder_ctrl;

  logic clk;
  logic rstN;

  logic       start8, abort8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, sumBit8;
  logic [7:0] sumOut8;
  logic [2:0] bitIdx8;

  logic       start4, abort4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4, sumBit4;
  logic [3:0] sumOut4;
  logic [1:0] bitIdx4;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
  } exp_t;

  exp_t expQ8[$];
  exp_t expQ4[$];

  int checks = 0;
  int errors = 0;

  logic       sumBitLog [0:255];
  logic [2:0] idxLog    [0:255];

  serial_adder_ctrl #(.WIDTH(8), .DIV(4)) dut8 (
    .CLK_IN(clk), .RST_N(rstN), .START(start8), .ABORT(abort8),
    .A_IN(a8), .B_IN(b8), .CIN(cin8), .BUSY(busy8), .DONE(done8),
    .SUM_OUT(sumOut8), .COUT(cout8), .SUM_BIT(sumBit8), .BIT_IDX(bitIdx8)
  );

  serial_adder_ctrl #(.WIDTH(4), .DIV(1)) dut4 (
    .CLK_IN(clk), .RST_N(rstN), .START(start4), .ABORT(abort4),
    .A_IN(a4), .B_IN(b4), .CIN(cin4), .BUSY(busy4), .DONE(done4),
    .SUM_OUT(sumOut4), .COUT(cout4), .SUM_BIT(sumBit4), .BIT_IDX(bitIdx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives a START for one edge (edge 0), queues the model result when
  // tracked, then scrambles the operand inputs to show they are not reused.
  task automatic applyStimulus(input bit sel4, input logic [7:0] a,
                               input logic [7:0] b, input logic c,
                               input bit track, input bit withAbort);
    logic [8:0] full;
    exp_t e;
    if (sel4) begin
      full = {5'd0, a[3:0]} + {5'd0, b[3:0]} + {8'd0, c};
      e.sum = {4'd0, full[3:0]};
      e.cout = full[4];
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; cin4 = c; abort4 = withAbort;
      if (track) expQ4.push_back(e);
    end else begin
      full = {1'b0, a} + {1'b0, b} + {8'd0, c};
      e.sum = full[7:0];
      e.cout = full[8];
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c; abort8 = withAbort;
      if (track) expQ8.push_back(e);
    end
    @(posedge clk);
    #1;
    start8 = 1'b0; abort8 = 1'b0; start4 = 1'b0; abort4 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
  endtask

  // Waits for DONE with a cycle budget; n counts edges after edge 0.
  task automatic waitDone(input bit sel4, input int bound,
                          output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < bound && !seen) begin
      @(negedge clk);
      sumBitLog[n] = sel4 ? sumBit4 : sumBit8;
      idxLog[n]    = sel4 ? {1'b0, bitIdx4} : bitIdx8;
      if ((sel4 ? done4 : done8) === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        n++;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    #3;
    checks++;
    if ({busy8, done8, sumOut8, cout8, sumBit8, bitIdx8} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL reset8 got %h expected 0",
               {busy8, done8, sumOut8, cout8, sumBit8, bitIdx8});
    end
    checks++;
    if ({busy4, done4, sumOut4, cout4, sumBit4, bitIdx4} !== 10'd0) begin
      errors++;
      $display("[TB] FAIL reset4 got %h expected 0",
               {busy4, done4, sumOut4, cout4, sumBit4, bitIdx4});
    end
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int n; bit seen; exp_t e;
    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0);
    waitDone(1'b0, 200, n, seen);
    checks++;
    if (!seen || n != 33) begin
      errors++;
      $display("[TB] FAIL basic_latency got %0d (seen %0d) expected 33", n, seen);
    end
    e = expQ8.pop_front();
    checks++;
    if (sumOut8 !== e.sum || cout8 !== e.cout) begin
      errors++;
      $display("[TB] FAIL basic_sum got %h/%b expected %h/%b", sumOut8, cout8, e.sum, e.cout);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (sumBitLog[4*k+5] !== e.sum[k]) begin
        errors++;
        $display("[TB] FAIL basic_sumbit%0d got %b expected %b", k, sumBitLog[4*k+5], e.sum[k]);
      end
    end
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (idxLog[4*k+5] !== 3'(k + 1)) begin
        errors++;
        $display("[TB] FAIL basic_idx%0d got %0d expected %0d", k, idxLog[4*k+5], k + 1);
      end
    end
    checks++;
    if (busy8 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_busy_done got %b expected 1", busy8);
    end
    @(negedge clk);
    checks++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_pulse got done %b busy %b expected 0 0", done8, busy8);
    end
  endtask

  task automatic test_back_to_back();
    int n; bit seen; exp_t e;
    applyStimulus(1'b0, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    waitDone(1'b0, 200, n, seen);
    e = expQ8.pop_front();
    checks++;
    if (!seen || sumOut8 !== e.sum || cout8 !== e.cout) begin
      errors++;
      $display("[TB] FAIL b2b_first got %h/%b expected %h/%b", sumOut8, cout8, e.sum, e.cout);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
    waitDone(1'b0, 200, n, seen);
    e = expQ8.pop_front();
    checks++;
    if (!seen || n != 33) begin
      errors++;
      $display("[TB] FAIL b2b_latency got %0d (seen %0d) expected 33", n, seen);
    end
    checks++;
    if (sumOut8 !== e.sum || cout8 !== e.cout) begin
      errors++;
      $display("[TB] FAIL b2b_second got %h/%b expected %h/%b", sumOut8, cout8, e.sum, e.cout);
    end
  endtask

  task automatic test_start_while_busy();
    int n; bit seen; exp_t e; int extraDone;
    applyStimulus(1'b0, 8'h10, 8'h20, 1'b0, 1'b1, 1'b1);
    fork
      waitDone(1'b0, 200, n, seen);
      begin
        repeat (4) @(posedge clk);
        #1; start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(posedge clk);
        #1; start8 = 1'b0;
        repeat (14) @(posedge clk);
        #1; start8 = 1'b1; a8 = 8'h77;
        @(posedge clk);
        #1; start8 = 1'b0;
      end
    join
    e = expQ8.pop_front();
    checks++;
    if (!seen || sumOut8 !== e.sum || cout8 !== e.cout) begin
      errors++;
      $display("[TB] FAIL busy_start got %h/%b expected %h/%b", sumOut8, cout8, e.sum, e.cout);
    end
    extraDone = 0;
    repeat (60) begin
      @(negedge clk);
      if (done8 === 1'b1) extraDone++;
    end
    checks++;
    if (extraDone != 0) begin
      errors++;
      $display("[TB] FAIL busy_extra_done got %0d expected 0", extraDone);
    end
  endtask

  task automatic test_abort();
    int n; bit seen; exp_t e; int sawDone;
    applyStimulus(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1, 1'b0);
    waitDone(1'b0, 200, n, seen);
    e = expQ8.pop_front();
    checks++;
    if (!seen || sumOut8 !== e.sum) begin
      errors++;
      $display("[TB] FAIL abort_setup got %h expected %h", sumOut8, e.sum);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);
    repeat (13) @(posedge clk);
    #1; abort8 = 1'b1;
    @(posedge clk);
    #1; abort8 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0 || bitIdx8 !== 3'd0) begin
      errors++;
      $display("[TB] FAIL abort_busy got busy %b idx %0d expected 0 0", busy8, bitIdx8);
    end
    sawDone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done8 === 1'b1) sawDone++;
    end
    checks++;
    if (sawDone != 0 || sumOut8 !== 8'h96 || cout8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_hold got done %0d sum %h/%b expected 0 96/0", sawDone, sumOut8, cout8);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b0);
    waitDone(1'b0, 200, n, seen);
    e = expQ8.pop_front();
    checks++;
    if (!seen || sumOut8 !== e.sum || cout8 !== e.cout) begin
      errors++;
      $display("[TB] FAIL abort_restart got %h/%b expected %h/%b", sumOut8, cout8, e.sum, e.cout);
    end
  endtask

  task automatic test_async_reset();
    int sawDone;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 8'h33, 8'h44, 1'b1, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #2; rstN = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, sumOut8, cout8, sumBit8, bitIdx8} !== 15'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got %h expected 0",
               {busy8, done8, sumOut8, cout8, sumBit8, bitIdx8});
    end
    @(negedge clk);
    rstN = 1'b1;
    sawDone = 0;
    repeat (50) begin
      @(negedge clk);
      if (done8 === 1'b1) sawDone++;
    end
    checks++;
    if (sawDone != 0 || busy8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_no_done got done %0d busy %b expected 0 0", sawDone, busy8);
    end
  endtask

  task automatic test_div1();
    int n; bit seen; exp_t e;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h09, 8'h08, 1'b1, 1'b1, 1'b0);
    waitDone(1'b1, 100, n, seen);
    e = expQ4.pop_front();
    checks++;
    if (!seen || n != 5) begin
      errors++;
      $display("[TB] FAIL div1_latency got %0d (seen %0d) expected 5", n, seen);
    end
    checks++;
    if ({4'd0, sumOut4} !== e.sum || cout4 !== e.cout) begin
      errors++;
      $display("[TB] FAIL div1_sum got %h/%b expected %h/%b", sumOut4, cout4, e.sum, e.cout);
    end
  endtask

  initial begin
    start8 = 0; abort8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start4 = 0; abort4 = 0; a4 = 0; b4 = 0; cin4 = 0;
    rstN = 1'b1;
    #2;
    test_reset();
    test_basic();
    @(posedge clk); #1;
    test_back_to_back();
    @(posedge clk); #1;
    test_start_while_busy();
    @(posedge clk); #1;
    test_abort();
    test_async_reset();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
